// File: rtl/signed_calc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : signed_calc_pkg
// Description : Shared definitions for the signed calculator result path:
//               FSM state encoding, default word/digit sizes and the
//               double-dabble correction constants.
// Revision    : 1.0 - initial release
// ============================================================================
package signed_calc_pkg;

  localparam int WIDTH_DEFAULT  = 8;
  localparam int DIGITS_DEFAULT = 3;
  localparam int BCD_CORRECT    = 3;
  localparam int BCD_THRESH     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEG  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/signed_result_decoder_dabble_digit.sv
`default_nettype none
// ============================================================================
// Module      : dabble_digit
// Description : Double-dabble correction for one BCD digit. A digit of five
//               or more gets three added so that the following left shift
//               carries into the next decimal digit.
// Ports       : digit_in  [3:0]  BCD digit before correction
//               digit_out [3:0]  corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module dabble_digit
  import signed_calc_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'(BCD_THRESH)) ? digit_in + 4'(BCD_CORRECT)
                                                  : digit_in;

endmodule
`default_nettype wire

// File: rtl/signed_result_decoder.sv
`default_nettype none
// ============================================================================
// Module      : signed_result_decoder
// Description : Turns a two's-complement result into sign, magnitude and
//               BCD digits. A bit-serial negation phase (WIDTH cycles) is
//               followed by a serial double-dabble phase (WIDTH cycles), so
//               out_valid rises a fixed 2*WIDTH edges after the accept edge.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               in_valid/in_ready/in_data input handshake (ready only in IDLE)
//               out_valid/out_ready      output handshake (valid only in DONE)
//               out_sign                 1 = negative
//               out_mag   [WIDTH-1:0]    unsigned magnitude
//               out_bcd   [4*DIGITS-1:0] magnitude in BCD, digit 0 at [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module signed_result_decoder
  import signed_calc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [WIDTH-1:0]      out_mag,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic                sign_r;
  logic                seen_r;     // a 1 has already passed in the NEG phase
  logic [WIDTH-1:0]    sh_r;       // NEG: input bits, LSB out; CONV: magnitude, MSB out
  logic [WIDTH-1:0]    mag_r;      // magnitude assembled MSB-in during NEG
  logic [BCD_W-1:0]    bcd_r;
  logic [BCD_W-1:0]    bcd_corr;
  logic [BCD_W-1:0]    bcd_next;
  logic                neg_bit;
  logic [WIDTH-1:0]    neg_mag_next;

  // Two's-complement negation LSB-first: copy through the first 1, invert after.
  assign neg_bit      = sh_r[0] ^ (sign_r & seen_r);
  assign neg_mag_next = {neg_bit, mag_r[WIDTH-1:1]};

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      dabble_digit u_dabble (
        .digit_in  (bcd_r[4*d +: 4]),
        .digit_out (bcd_corr[4*d +: 4])
      );
    end
  endgenerate

  assign bcd_next = {bcd_corr[BCD_W-2:0], sh_r[WIDTH-1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_NEG;
      end
      ST_NEG:  if (cnt == LAST) next_state = ST_CONV;
      ST_CONV: if (cnt == LAST) next_state = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sign_r   <= 1'b0;
      seen_r   <= 1'b0;
      sh_r     <= '0;
      mag_r    <= '0;
      bcd_r    <= '0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_bcd  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sh_r   <= in_data;
            sign_r <= in_data[WIDTH-1];
            seen_r <= 1'b0;
            cnt    <= '0;
            mag_r  <= '0;
            bcd_r  <= '0;
          end
        end
        ST_NEG: begin
          mag_r  <= neg_mag_next;
          seen_r <= seen_r | sh_r[0];
          if (cnt == LAST) begin
            cnt  <= '0;
            sh_r <= neg_mag_next;   // hand the finished magnitude to CONV
          end else begin
            cnt  <= cnt + 1'b1;
            sh_r <= sh_r >> 1;
          end
        end
        ST_CONV: begin
          bcd_r <= bcd_next;
          sh_r  <= {sh_r[WIDTH-2:0], 1'b0};
          if (cnt == LAST) begin
            cnt      <= '0;
            out_sign <= sign_r;
            out_mag  <= mag_r;
            out_bcd  <= bcd_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
